// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the control sequencer: state enum, opcodes,
// register-file/ARF/ALU select codes and the control bundle struct.
package ctrl_pkg;

  typedef enum logic [1:0] {
    S_T0   = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [5:0] OP_BRA  = 6'h00;
  localparam logic [5:0] OP_INC  = 6'h05;
  localparam logic [5:0] OP_DEC  = 6'h06;
  localparam logic [5:0] OP_MOVL = 6'h11;
  localparam logic [5:0] OP_STL  = 6'h12;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_WLCH = 3'b100;

  localparam logic [2:0] ARF_SEL_PC = 3'b100;
  localparam logic [1:0] ARF_OUT_PC = 2'b00;
  localparam logic [1:0] ARF_OUT_AR = 2'b10;
  localparam logic [4:0] ALU_PASS_A = 5'b10000;
  localparam logic [1:0] MUX_SEL_IR = 2'b11;

  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [2:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [4:0] alu_fun_sel;
    logic       alu_wf;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [2:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  // Idle bundle: nothing selected, memory deselected (Mem_CS is active-low).
  function automatic ctrl_t idle_ctrl();
    ctrl_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  // Instruction fetch half: read memory at PC into IR half lh, then PC+1.
  function automatic ctrl_t fetch_ctrl(input logic lh);
    ctrl_t c;
    c              = idle_ctrl();
    c.arf_outd_sel = ARF_OUT_PC;
    c.mem_cs       = 1'b0;
    c.ir_write     = 1'b1;
    c.ir_lh        = lh;
    c.arf_reg_sel  = ARF_SEL_PC;
    c.arf_fun_sel  = FUN_INC;
    return c;
  endfunction

  // RSEL 0..3 -> R1..R4, one-hot MSB-first.
  function automatic logic [3:0] rf_onehot(input logic [1:0] rsel);
    return 4'b1000 >> rsel;
  endfunction

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode -> execute-cycle control bundle.
// ILLEGAL_TRAP_EN: when defined, unknown opcodes raise illegal_c; otherwise they decode as NOP.
module op_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [1:0] rsel,
  output ctrl_t      ctrl_c,
  output logic       halt_c,
  output logic       illegal_c
);

  always_comb begin
    ctrl_c    = idle_ctrl();
    halt_c    = 1'b0;
    illegal_c = 1'b0;
    case (opcode)
      OP_BRA: begin
        ctrl_c.mux_b_sel   = MUX_SEL_IR;
        ctrl_c.arf_reg_sel = ARF_SEL_PC;
        ctrl_c.arf_fun_sel = FUN_LOAD;
      end
      OP_INC: begin
        ctrl_c.rf_reg_sel = rf_onehot(rsel);
        ctrl_c.rf_fun_sel = FUN_INC;
      end
      OP_DEC: begin
        ctrl_c.rf_reg_sel = rf_onehot(rsel);
        ctrl_c.rf_fun_sel = FUN_DEC;
      end
      OP_MOVL: begin
        ctrl_c.mux_a_sel  = MUX_SEL_IR;
        ctrl_c.rf_reg_sel = rf_onehot(rsel);
        ctrl_c.rf_fun_sel = FUN_WLCH;
      end
      OP_STL: begin
        ctrl_c.rf_outa_sel  = {1'b0, rsel};
        ctrl_c.alu_fun_sel  = ALU_PASS_A;
        ctrl_c.mux_c_sel    = 1'b0;
        ctrl_c.arf_outd_sel = ARF_OUT_AR;
        ctrl_c.mem_cs       = 1'b0;
        ctrl_c.mem_wr       = 1'b1;
      end
      OP_HLT: halt_c = 1'b1;
      default: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_c = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Three-cycle fetch/fetch/execute control sequencer with a sticky HALT state.
// ILLEGAL_TRAP_EN (in op_decoder): unknown opcodes trap to HALT and set Illegal.
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [1:0]  T_State,
  output logic        Halted,
  output logic        Illegal
);

  state_t state, state_nxt;
  ctrl_t  ctrl, dec_ctrl;
  logic   dec_halt, dec_illegal;
  logic   illegal_q;

  // The immediate byte feeds the datapath directly, not the sequencer.
  logic unused_value;
  assign unused_value = ^IROut[7:0];

  op_decoder u_dec (
    .opcode    (IROut[15:10]),
    .rsel      (IROut[9:8]),
    .ctrl_c    (dec_ctrl),
    .halt_c    (dec_halt),
    .illegal_c (dec_illegal)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_T0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_T2 && dec_illegal) illegal_q <= 1'b1;
    end
  end

  // Next state and Moore outputs; Reset forces the idle bundle so no write leaks.
  always_comb begin
    state_nxt = state;
    ctrl      = idle_ctrl();
    case (state)
      S_T0: begin
        ctrl      = fetch_ctrl(1'b0);
        state_nxt = S_T1;
      end
      S_T1: begin
        ctrl      = fetch_ctrl(1'b1);
        state_nxt = S_T2;
      end
      S_T2: begin
        ctrl      = dec_ctrl;
        state_nxt = (dec_halt || dec_illegal) ? S_HALT : S_T0;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_T0;
    endcase
    if (Reset) ctrl = idle_ctrl();
  end

  assign RF_OutASel  = ctrl.rf_outa_sel;
  assign RF_OutBSel  = ctrl.rf_outb_sel;
  assign RF_FunSel   = ctrl.rf_fun_sel;
  assign RF_RegSel   = ctrl.rf_reg_sel;
  assign RF_ScrSel   = ctrl.rf_scr_sel;
  assign ALU_FunSel  = ctrl.alu_fun_sel;
  assign ALU_WF      = ctrl.alu_wf;
  assign ARF_OutCSel = ctrl.arf_outc_sel;
  assign ARF_OutDSel = ctrl.arf_outd_sel;
  assign ARF_FunSel  = ctrl.arf_fun_sel;
  assign ARF_RegSel  = ctrl.arf_reg_sel;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_Write    = ctrl.ir_write;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;
  assign MuxASel     = ctrl.mux_a_sel;
  assign MuxBSel     = ctrl.mux_b_sel;
  assign MuxCSel     = ctrl.mux_c_sel;
  assign T_State     = state;
  assign Halted      = (state == S_HALT);
  assign Illegal     = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; expectations are hand-derived.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [1:0]  T_State;
  logic        Halted, Illegal;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
    .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .T_State(T_State), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample on the following falling edge.
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk_fetch(input string tag, input logic lh);
    chk({tag, ".ARF_RegSel"}, 32'(ARF_RegSel), 32'h4);
    chk({tag, ".ARF_FunSel"}, 32'(ARF_FunSel), 32'h1);
    chk({tag, ".ARF_OutDSel"}, 32'(ARF_OutDSel), 32'h0);
    chk({tag, ".IR_Write"}, 32'(IR_Write), 32'h1);
    chk({tag, ".IR_LH"}, 32'(IR_LH), 32'(lh));
    chk({tag, ".Mem_CS"}, 32'(Mem_CS), 32'h0);
    chk({tag, ".Mem_WR"}, 32'(Mem_WR), 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    Reset = 1'b1;
    #2;
    chk("rst.T_State", 32'(T_State), 32'h0);
    chk("rst.IR_Write", 32'(IR_Write), 32'h0);
    chk("rst.Mem_CS", 32'(Mem_CS), 32'h1);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    IROut = 16'h0042;
    #12;
    chk("reset.T_State", 32'(T_State), 32'h0);
    chk("reset.Halted", 32'(Halted), 32'h0);
    chk("reset.Illegal", 32'(Illegal), 32'h0);
    chk("reset.IR_Write", 32'(IR_Write), 32'h0);
    chk("reset.Mem_CS", 32'(Mem_CS), 32'h1);
    chk("reset.ARF_RegSel", 32'(ARF_RegSel), 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;

    // BRA 0x42
    chk("bra.T0.T_State", 32'(T_State), 32'h0);
    chk_fetch("bra.T0", 1'b0);
    step();
    chk("bra.T1.T_State", 32'(T_State), 32'h1);
    chk_fetch("bra.T1", 1'b1);
    step();
    chk("bra.T2.T_State", 32'(T_State), 32'h2);
    chk("bra.T2.MuxBSel", 32'(MuxBSel), 32'h3);
    chk("bra.T2.ARF_RegSel", 32'(ARF_RegSel), 32'h4);
    chk("bra.T2.ARF_FunSel", 32'(ARF_FunSel), 32'h2);
    chk("bra.T2.IR_Write", 32'(IR_Write), 32'h0);
    chk("bra.T2.Mem_CS", 32'(Mem_CS), 32'h1);
    step();
    chk("bra.next.T_State", 32'(T_State), 32'h0);

    // MOVL R3,0x55
    IROut = 16'h4655;
    step(); step();
    chk("movl.MuxASel", 32'(MuxASel), 32'h3);
    chk("movl.RF_RegSel", 32'(RF_RegSel), 32'h2);
    chk("movl.RF_FunSel", 32'(RF_FunSel), 32'h4);
    chk("movl.Mem_CS", 32'(Mem_CS), 32'h1);
    chk("movl.ARF_RegSel", 32'(ARF_RegSel), 32'h0);
    step();

    // STL R2
    IROut = 16'h4900;
    step(); step();
    chk("stl.RF_OutASel", 32'(RF_OutASel), 32'h1);
    chk("stl.ALU_FunSel", 32'(ALU_FunSel), 32'h10);
    chk("stl.ARF_OutDSel", 32'(ARF_OutDSel), 32'h2);
    chk("stl.MuxCSel", 32'(MuxCSel), 32'h0);
    chk("stl.Mem_CS", 32'(Mem_CS), 32'h0);
    chk("stl.Mem_WR", 32'(Mem_WR), 32'h1);
    chk("stl.RF_RegSel", 32'(RF_RegSel), 32'h0);
    step();

    // INC R4
    IROut = 16'h1700;
    step(); step();
    chk("inc.RF_RegSel", 32'(RF_RegSel), 32'h1);
    chk("inc.RF_FunSel", 32'(RF_FunSel), 32'h1);
    step();

    // DEC R1
    IROut = 16'h1800;
    step(); step();
    chk("dec.RF_RegSel", 32'(RF_RegSel), 32'h8);
    chk("dec.RF_FunSel", 32'(RF_FunSel), 32'h0);
    step();

    // Reset mid-T1 abandons the instruction
    chk("midrst.pre.T_State", 32'(T_State), 32'h0);
    step();
    chk("midrst.T1.T_State", 32'(T_State), 32'h1);
    #2 Reset = 1'b1;
    #1;
    chk("midrst.T_State", 32'(T_State), 32'h0);
    chk("midrst.IR_Write", 32'(IR_Write), 32'h0);
    chk("midrst.Mem_CS", 32'(Mem_CS), 32'h1);
    chk("midrst.RF_RegSel", 32'(RF_RegSel), 32'h0);
    #1 Reset = 1'b0;
    #1;
    chk("midrst.after.T_State", 32'(T_State), 32'h0);
    chk("midrst.after.IR_Write", 32'(IR_Write), 32'h1);
    @(negedge Clock);
    chk("midrst.T1again", 32'(T_State), 32'h1);
    step();
    step();
    chk("midrst.back.T_State", 32'(T_State), 32'h0);

    // Illegal opcode 0x0A
    IROut = 16'h2800;
    step(); step();
    chk("ill.T2.T_State", 32'(T_State), 32'h2);
    chk("ill.T2.RF_RegSel", 32'(RF_RegSel), 32'h0);
    chk("ill.T2.Mem_CS", 32'(Mem_CS), 32'h1);
    step();
`ifdef ILLEGAL_TRAP_EN
    chk("ill.T_State", 32'(T_State), 32'h3);
    chk("ill.Illegal", 32'(Illegal), 32'h1);
    chk("ill.Halted", 32'(Halted), 32'h1);
    step();
    chk("ill.sticky", 32'(Illegal), 32'h1);
    pulse_reset();
    #1;
    chk("ill.clr.Illegal", 32'(Illegal), 32'h0);
    chk("ill.clr.T_State", 32'(T_State), 32'h0);
`else
    chk("ill.T_State", 32'(T_State), 32'h0);
    chk("ill.Illegal", 32'(Illegal), 32'h0);
    chk("ill.Halted", 32'(Halted), 32'h0);
`endif

    // HLT
    IROut = 16'hFC00;
    step(); step();
    chk("hlt.T2.Halted", 32'(Halted), 32'h0);
    step();
    chk("hlt.T_State", 32'(T_State), 32'h3);
    chk("hlt.Halted", 32'(Halted), 32'h1);
    IROut = 16'h0042;
    repeat (10) step();
    chk("hlt.hold.T_State", 32'(T_State), 32'h3);
    chk("hlt.hold.Mem_CS", 32'(Mem_CS), 32'h1);
    chk("hlt.hold.IR_Write", 32'(IR_Write), 32'h0);
    chk("hlt.hold.ARF_RegSel", 32'(ARF_RegSel), 32'h0);
    chk("hlt.hold.RF_RegSel", 32'(RF_RegSel), 32'h0);
    pulse_reset();
    #1;
    chk("hlt.exit.T_State", 32'(T_State), 32'h0);
    chk("hlt.exit.Halted", 32'(Halted), 32'h0);
    chk_fetch("hlt.exit", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-high; forces sequencer to T0 immediately.
REQ-003 IROut  in  16  instruction register contents: [15:10] opcode, [9:8] RSEL, [7:0] VALUE.
REQ-004 RF_OutASel/RF_OutBSel out 3, RF_FunSel out 3, RF_RegSel out 4, RF_ScrSel out 4  register-file controls.
REQ-005 ALU_FunSel out 5, ALU_WF out 1  ALU controls.
REQ-006 ARF_OutCSel/ARF_OutDSel out 2, ARF_FunSel out 3, ARF_RegSel out 3  address-register-file controls.
REQ-007 IR_LH out 1, IR_Write out 1, Mem_WR out 1, Mem_CS out 1 (active-low), MuxASel/MuxBSel out 2, MuxCSel out 1  fetch/memory/mux controls.
REQ-008 T_State out 2  current state (0=T0, 1=T1, 2=T2, 3=HALT); Halted out 1; Illegal out 1.

Function
REQ-009 SHALL be a Moore-style FSM: T0 -> T1 -> T2 -> T0, all outputs combinational from state and IROut.
REQ-010 Encodings: RF_RegSel one-hot active-high {R1,R2,R3,R4} MSB-first; ARF_RegSel {PC,AR,SP} MSB-first; ARF_OutDSel 00=PC, 10=AR; FunSel 000 DEC, 001 INC, 010 LOAD, 100 write-low/clear-high; ALU_FunSel 10000 = pass A.
REQ-011 Idle defaults every state unless overridden: all RegSel/ScrSel 0, Mem_CS=1, Mem_WR=0, IR_Write=0, ALU_WF=0, selects 0.
REQ-012 T0: ARF_OutDSel=00, Mem_CS=0, Mem_WR=0, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=001 (PC+1).
REQ-013 T1: identical to T0 except IR_LH=1.
REQ-014 T2 execute, RSEL selects R1..R4, exactly one cycle, then T0:
 - 0x00 BRA: MuxBSel=11, ARF_RegSel=100, ARF_FunSel=010.
 - 0x05 INC: RF_RegSel=RSEL bit, RF_FunSel=001.
 - 0x06 DEC: RF_RegSel=RSEL bit, RF_FunSel=000.
 - 0x11 MOVL: MuxASel=11, RF_RegSel=RSEL bit, RF_FunSel=100.
 - 0x12 STL: RF_OutASel=RSEL, ALU_FunSel=10000, MuxCSel=0, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
 - 0x3F HLT: next state HALT.
 - any other opcode: illegal (REQ-020).
REQ-015 HALT: idle defaults, Halted=1, no exit except Reset.
REQ-016 No memory or register write SHALL be asserted in HALT or during Reset.
REQ-017 Instruction latency fixed at 3 cycles; PC advances by exactly 2 per non-branch instruction.

Reset
REQ-018 On Reset: state=T0, Halted=0, Illegal=0; outputs show T0 pattern once Reset deasserts, idle defaults while asserted.
REQ-019 Reset asserted mid-instruction (T1/T2/HALT) SHALL abandon it; no partial write after deassertion.

Configuration
REQ-020 Macro ILLEGAL_TRAP_EN: defined -> illegal opcode in T2 sets sticky Illegal=1 and enters HALT; undefined -> treated as NOP, Illegal tied 0, returns to T0.

Structure
REQ-021 Package ctrl_pkg SHALL hold state enum, opcode constants, FunSel/RegSel/select encodings.
REQ-022 Sub-module op_decoder (combinational opcode -> T2 control bundle) is natural; FSM stays in top.

Verification
REQ-023 Reset then 3 clocks with IROut=0x0042 (BRA 0x42): T0/T1 show PC INC+IR_Write LH 0/1; T2 shows MuxBSel=11, ARF_RegSel=100, FunSel=010.
REQ-024 IROut=0x4655 (MOVL R3,0x55) in T2: MuxASel=11, RF_RegSel=0010, RF_FunSel=100, Mem_CS=1.
REQ-025 IROut=0x4900 (STL R2) in T2: RF_OutASel=001, ALU_FunSel=10000, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
REQ-026 IROut=0xFC00 (HLT): T_State=3, Halted=1 after T2; 10 further clocks stay HALT, Mem_CS=1; Reset returns to T0.
REQ-027 IROut=0x2800 (opcode 0x0A): with ILLEGAL_TRAP_EN Illegal=1, HALT; without, next state T0, Illegal=0.
REQ-028 Reset pulsed asynchronously mid-T1: T_State=0 before next edge, IR_Write=0 while asserted.
